// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: hazard and pipeline-register controller for the five-stage CPU.
// Resolves data-memory wait, EX-resolved taken branches, load-use hazards and
// ID-resolved jumps into PC / IF-ID / ID-EX / EX-MEM controls, and keeps
// saturating stall/bubble/flush statistics plus a sticky memory-timeout flag.
module pipeline_ctrl #(
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 1023
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_rs_used,
  input  logic             id_rt_used,
  input  logic             id_jump,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_rt,
  input  logic             ex_branch_taken,
  input  logic             mem_wait,
  input  logic             stat_clr,
  output logic             pc_write,
  output logic             id_redirect_en,
  output logic [1:0]       if_id_option,
  output logic [1:0]       id_ex_option,
  output logic             ex_mem_hold,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] bubble_count,
  output logic [CNT_W-1:0] flush_count,
  output logic             mem_timeout
);

  // Pipeline-register update options understood by the stage registers.
  // Code 2'b11 is deliberately never produced.
  typedef enum logic [1:0] {
    OPT_UPDATE = 2'b00,
    OPT_BUBBLE = 2'b01,
    OPT_HOLD   = 2'b10
  } regOpt_e;

  // Which hazard rule wins this cycle, highest priority first in the decode.
  typedef enum logic [2:0] {
    P_RUN,
    P_JUMP,
    P_LOADUSE,
    P_BRANCH,
    P_HOLD
  } mode_e;

  // Memory-wait tracking state.
  typedef enum logic {
    S_RUN,
    S_WAIT
  } state_e;

  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

  logic             loadUse;
  mode_e            mode;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] waitCnt_q, waitCnt_d;
  logic             waitStep;
  logic             timeoutHit;
  logic             memTimeout_q, memTimeout_d;

  logic [CNT_W-1:0] stallCnt_q, stallCnt_d;
  logic [CNT_W-1:0] bubbleCnt_q, bubbleCnt_d;
  logic [CNT_W-1:0] flushCnt_q, flushCnt_d;
  logic             incStall;
  logic             incBubble;
  logic             incFlush;

  // Saturating increment used by every statistics counter.
  function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] value,
                                              input logic             en);
    logic [CNT_W-1:0] result;
    result = value;
    if (en && (value != CNT_MAX)) begin
      result = value + CNT_W'(1);
    end
    return result;
  endfunction

  // Load-use hazard: the load in EX writes a non-zero register that ID really reads.
  always_comb begin
    loadUse = ex_mem_read && (ex_rt != 5'd0) &&
              ((id_rs_used && (id_rs == ex_rt)) ||
               (id_rt_used && (id_rt == ex_rt)));
  end

  // Pick the winning rule; a taken branch outranks load-use and jump because
  // both of those belong to wrong-path instructions.
  always_comb begin
    mode = P_RUN;
    if (mem_wait) begin
      mode = P_HOLD;
    end else if (ex_branch_taken) begin
      mode = P_BRANCH;
    end else if (loadUse) begin
      mode = P_LOADUSE;
    end else if (id_jump) begin
      mode = P_JUMP;
    end
  end

  // Translate the winning rule into the stage-register and PC controls.
  always_comb begin
    pc_write       = 1'b1;
    id_redirect_en = 1'b0;
    if_id_option   = OPT_UPDATE;
    id_ex_option   = OPT_UPDATE;
    ex_mem_hold    = 1'b0;
    unique case (mode)
      P_HOLD: begin
        pc_write     = 1'b0;
        if_id_option = OPT_HOLD;
        id_ex_option = OPT_HOLD;
        ex_mem_hold  = 1'b1;
      end
      P_BRANCH: begin
        if_id_option = OPT_BUBBLE;
        id_ex_option = OPT_BUBBLE;
      end
      P_LOADUSE: begin
        pc_write     = 1'b0;
        if_id_option = OPT_HOLD;
        id_ex_option = OPT_BUBBLE;
      end
      P_JUMP: begin
        id_redirect_en = 1'b1;
        if_id_option   = OPT_BUBBLE;
      end
      default: begin
        pc_write = 1'b1;
      end
    endcase
  end

  // Wait-state next-state logic. The count includes the cycle that caused
  // entry, so it equals the number of consecutive mem_wait cycles seen.
  always_comb begin
    state_d   = state_q;
    waitCnt_d = waitCnt_q;
    waitStep  = 1'b0;
    unique case (state_q)
      S_RUN: begin
        if (mem_wait) begin
          state_d   = S_WAIT;
          waitCnt_d = CNT_W'(1);
          waitStep  = 1'b1;
        end
      end
      S_WAIT: begin
        if (mem_wait) begin
          if (waitCnt_q != TIMEOUT_C) begin
            waitCnt_d = waitCnt_q + CNT_W'(1);
            waitStep  = 1'b1;
          end
        end else begin
          state_d = S_RUN;
        end
      end
      default: begin
        state_d = S_RUN;
      end
    endcase
    timeoutHit   = waitStep && (waitCnt_d == TIMEOUT_C);
    memTimeout_d = stat_clr ? 1'b0 : (memTimeout_q | timeoutHit);
  end

  // Wait-state FSM register with its counter and the sticky timeout flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_RUN;
      waitCnt_q    <= '0;
      memTimeout_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      waitCnt_q    <= waitCnt_d;
      memTimeout_q <= memTimeout_d;
    end
  end

  // Statistics next values; a clear request beats any same-cycle increment.
  always_comb begin
    incStall  = (mode == P_HOLD) || (mode == P_LOADUSE);
    incBubble = (id_ex_option == OPT_BUBBLE);
    incFlush  = (mode == P_BRANCH) || (mode == P_JUMP);
    if (stat_clr) begin
      stallCnt_d  = '0;
      bubbleCnt_d = '0;
      flushCnt_d  = '0;
    end else begin
      stallCnt_d  = satInc(stallCnt_q, incStall);
      bubbleCnt_d = satInc(bubbleCnt_q, incBubble);
      flushCnt_d  = satInc(flushCnt_q, incFlush);
    end
  end

  // Statistics counter registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stallCnt_q  <= '0;
      bubbleCnt_q <= '0;
      flushCnt_q  <= '0;
    end else begin
      stallCnt_q  <= stallCnt_d;
      bubbleCnt_q <= bubbleCnt_d;
      flushCnt_q  <= flushCnt_d;
    end
  end

  assign stall_cycles = stallCnt_q;
  assign bubble_count = bubbleCnt_q;
  assign flush_count  = flushCnt_q;
  assign mem_timeout  = memTimeout_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb_pipeline_ctrl: directed bench for pipeline_ctrl built with CNT_W=4 and
// TIMEOUT=4 so counter saturation and the timeout flag are reachable quickly.
module tb_pipeline_ctrl;

  localparam int CNT_W   = 4;
  localparam int TIMEOUT = 4;

  // Control vector layout: {pc_write, id_redirect_en, if_id, id_ex, ex_mem_hold}
  localparam logic [6:0] CTL_RUN    = 7'b1_0_00_00_0;
  localparam logic [6:0] CTL_HOLD   = 7'b0_0_10_10_1;
  localparam logic [6:0] CTL_BRANCH = 7'b1_0_01_01_0;
  localparam logic [6:0] CTL_LU     = 7'b0_0_10_01_0;
  localparam logic [6:0] CTL_JUMP   = 7'b1_1_01_00_0;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [4:0]       id_rs, id_rt, ex_rt;
  logic             id_rs_used, id_rt_used, id_jump;
  logic             ex_mem_read, ex_branch_taken, mem_wait, stat_clr;
  logic             pc_write, id_redirect_en, ex_mem_hold, mem_timeout;
  logic [1:0]       if_id_option, id_ex_option;
  logic [CNT_W-1:0] stall_cycles, bubble_count, flush_count;

  logic [6:0]  ctl;
  logic [12:0] stats;
  int checks = 0;
  int errors = 0;

  assign ctl   = {pc_write, id_redirect_en, if_id_option, id_ex_option, ex_mem_hold};
  assign stats = {stall_cycles, bubble_count, flush_count, mem_timeout};

  pipeline_ctrl #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .id_rs(id_rs), .id_rt(id_rt), .id_rs_used(id_rs_used), .id_rt_used(id_rt_used),
    .id_jump(id_jump), .ex_mem_read(ex_mem_read), .ex_rt(ex_rt),
    .ex_branch_taken(ex_branch_taken), .mem_wait(mem_wait), .stat_clr(stat_clr),
    .pc_write(pc_write), .id_redirect_en(id_redirect_en),
    .if_id_option(if_id_option), .id_ex_option(id_ex_option),
    .ex_mem_hold(ex_mem_hold), .stall_cycles(stall_cycles),
    .bubble_count(bubble_count), .flush_count(flush_count), .mem_timeout(mem_timeout)
  );

  // 10 ns clock; inputs change on the falling edge, outputs sampled 1 ns later
  // or 1 ns after the rising edge.
  always #5 clk = ~clk;

  // Guard against a hung run.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout want finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic applyStimulus(input logic [4:0] rs, input logic rsUsed,
                               input logic [4:0] rt, input logic rtUsed,
                               input logic jump, input logic memRead,
                               input logic [4:0] exRt, input logic br,
                               input logic mw, input logic clr);
    id_rs = rs; id_rs_used = rsUsed; id_rt = rt; id_rt_used = rtUsed;
    id_jump = jump; ex_mem_read = memRead; ex_rt = exRt;
    ex_branch_taken = br; mem_wait = mw; stat_clr = clr;
  endtask

  task automatic clearInputs();
    applyStimulus(5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic doReset();
    clearInputs();
    reset = 1'b0;
    #1;
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    clearInputs();
    #1 reset = 1'b0;
    #1;
    checks++;
    if (ctl !== CTL_RUN) begin
      errors++; $display("[TB] FAIL reset_ctl: got %b want %b", ctl, CTL_RUN);
    end
    checks++;
    if (stats !== 13'h0) begin
      errors++; $display("[TB] FAIL reset_stats: got %h want %h", stats, 13'h0);
    end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_load_use();
    doReset();
    applyStimulus(5'd8, 1'b1, 5'd3, 1'b0, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0);
    #1;
    checks++;
    if (ctl !== CTL_LU) begin
      errors++; $display("[TB] FAIL lu_ctl: got %b want %b", ctl, CTL_LU);
    end
    @(posedge clk); #1;
    checks++;
    if (stats !== {4'd1, 4'd1, 4'd0, 1'b0}) begin
      errors++; $display("[TB] FAIL lu_stats: got %h want %h", stats, {4'd1, 4'd1, 4'd0, 1'b0});
    end
    @(negedge clk);
    ex_mem_read = 1'b0;
    #1;
    checks++;
    if (ctl !== CTL_RUN) begin
      errors++; $display("[TB] FAIL lu_after_ctl: got %b want %b", ctl, CTL_RUN);
    end
    applyStimulus(5'd0, 1'b1, 5'd3, 1'b0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
    #1;
    checks++;
    if (ctl !== CTL_RUN) begin
      errors++; $display("[TB] FAIL lu_r0_ctl: got %b want %b", ctl, CTL_RUN);
    end
    applyStimulus(5'd8, 1'b0, 5'd8, 1'b1, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0);
    #1;
    checks++;
    if (ctl !== CTL_LU) begin
      errors++; $display("[TB] FAIL lu_rt_ctl: got %b want %b", ctl, CTL_LU);
    end
    applyStimulus(5'd8, 1'b0, 5'd9, 1'b1, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0);
    #1;
    checks++;
    if (ctl !== CTL_RUN) begin
      errors++; $display("[TB] FAIL lu_unused_ctl: got %b want %b", ctl, CTL_RUN);
    end
    @(posedge clk); #1;
    checks++;
    if (stats !== {4'd1, 4'd1, 4'd0, 1'b0}) begin
      errors++; $display("[TB] FAIL lu_end_stats: got %h want %h", stats, {4'd1, 4'd1, 4'd0, 1'b0});
    end
    @(negedge clk);
  endtask

  task automatic test_branch();
    doReset();
    applyStimulus(5'd8, 1'b1, 5'd0, 1'b0, 1'b1, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0);
    #1;
    checks++;
    if (ctl !== CTL_BRANCH) begin
      errors++; $display("[TB] FAIL br_ctl: got %b want %b", ctl, CTL_BRANCH);
    end
    @(posedge clk); #1;
    checks++;
    if (stats !== {4'd0, 4'd1, 4'd1, 1'b0}) begin
      errors++; $display("[TB] FAIL br_stats: got %h want %h", stats, {4'd0, 4'd1, 4'd1, 1'b0});
    end
    @(negedge clk);
  endtask

  task automatic test_jump();
    doReset();
    applyStimulus(5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    #1;
    checks++;
    if (ctl !== CTL_JUMP) begin
      errors++; $display("[TB] FAIL jmp_ctl: got %b want %b", ctl, CTL_JUMP);
    end
    @(posedge clk); #1;
    checks++;
    if (stats !== {4'd0, 4'd0, 4'd1, 1'b0}) begin
      errors++; $display("[TB] FAIL jmp_stats: got %h want %h", stats, {4'd0, 4'd0, 4'd1, 1'b0});
    end
    @(negedge clk);
    applyStimulus(5'd5, 1'b1, 5'd0, 1'b0, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0);
    #1;
    checks++;
    if (ctl !== CTL_LU) begin
      errors++; $display("[TB] FAIL jr_stall_ctl: got %b want %b", ctl, CTL_LU);
    end
    @(posedge clk); #1;
    checks++;
    if (stats !== {4'd1, 4'd1, 4'd1, 1'b0}) begin
      errors++; $display("[TB] FAIL jr_stall_stats: got %h want %h", stats, {4'd1, 4'd1, 4'd1, 1'b0});
    end
    @(negedge clk);
    ex_mem_read = 1'b0; ex_rt = 5'd0;
    #1;
    checks++;
    if (ctl !== CTL_JUMP) begin
      errors++; $display("[TB] FAIL jr_redirect_ctl: got %b want %b", ctl, CTL_JUMP);
    end
    @(posedge clk); #1;
    checks++;
    if (stats !== {4'd1, 4'd1, 4'd2, 1'b0}) begin
      errors++; $display("[TB] FAIL jr_end_stats: got %h want %h", stats, {4'd1, 4'd1, 4'd2, 1'b0});
    end
    @(negedge clk);
  endtask

  task automatic test_mem_wait();
    doReset();
    applyStimulus(5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0);
    for (int k = 1; k <= 3; k++) begin
      #1;
      checks++;
      if (ctl !== CTL_HOLD) begin
        errors++; $display("[TB] FAIL mw_hold_ctl[%0d]: got %b want %b", k, ctl, CTL_HOLD);
      end
      @(negedge clk);
    end
    mem_wait = 1'b0;
    #1;
    checks++;
    if (ctl !== CTL_BRANCH) begin
      errors++; $display("[TB] FAIL mw_branch_ctl: got %b want %b", ctl, CTL_BRANCH);
    end
    @(posedge clk); #1;
    checks++;
    if (stats !== {4'd3, 4'd1, 4'd1, 1'b0}) begin
      errors++; $display("[TB] FAIL mw_stats: got %h want %h", stats, {4'd3, 4'd1, 4'd1, 1'b0});
    end
    @(negedge clk);
    applyStimulus(5'd7, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1, 5'd7, 1'b0, 1'b1, 1'b0);
    #1;
    checks++;
    if (ctl !== CTL_HOLD) begin
      errors++; $display("[TB] FAIL mw_lu_hold_ctl: got %b want %b", ctl, CTL_HOLD);
    end
    @(negedge clk);
    mem_wait = 1'b0;
    #1;
    checks++;
    if (ctl !== CTL_LU) begin
      errors++; $display("[TB] FAIL mw_lu_after_ctl: got %b want %b", ctl, CTL_LU);
    end
    @(posedge clk); #1;
    checks++;
    if (stats !== {4'd5, 4'd2, 4'd1, 1'b0}) begin
      errors++; $display("[TB] FAIL mw_lu_stats: got %h want %h", stats, {4'd5, 4'd2, 4'd1, 1'b0});
    end
    @(negedge clk);
  endtask

  task automatic test_timeout();
    logic expT;
    doReset();
    mem_wait = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      expT = (k >= TIMEOUT);
      @(posedge clk); #1;
      checks++;
      if (mem_timeout !== expT) begin
        errors++; $display("[TB] FAIL to_flag[%0d]: got %b want %b", k, mem_timeout, expT);
      end
      @(negedge clk);
    end
    mem_wait = 1'b0;
    #1;
    checks++;
    if (ctl !== CTL_RUN) begin
      errors++; $display("[TB] FAIL to_resume_ctl: got %b want %b", ctl, CTL_RUN);
    end
    @(posedge clk); #1;
    checks++;
    if (stats !== {4'd6, 4'd0, 4'd0, 1'b1}) begin
      errors++; $display("[TB] FAIL to_sticky_stats: got %h want %h", stats, {4'd6, 4'd0, 4'd0, 1'b1});
    end
    @(negedge clk);
    applyStimulus(5'd8, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0, 1'b1);
    @(posedge clk); #1;
    checks++;
    if (stats !== 13'h0) begin
      errors++; $display("[TB] FAIL clr_stats: got %h want %h", stats, 13'h0);
    end
    @(negedge clk);
    clearInputs();
    @(posedge clk); #1;
    checks++;
    if (stats !== 13'h0) begin
      errors++; $display("[TB] FAIL clr_after_stats: got %h want %h", stats, 13'h0);
    end
    @(negedge clk);
  endtask

  task automatic test_saturation_and_reset();
    logic [12:0] expStats;
    doReset();
    mem_wait = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      expStats = {4'((k > 15) ? 15 : k), 4'd0, 4'd0, 1'((k >= TIMEOUT) ? 1 : 0)};
      @(posedge clk); #1;
      checks++;
      if (stats !== expStats) begin
        errors++; $display("[TB] FAIL sat_stats[%0d]: got %h want %h", k, stats, expStats);
      end
    end
    #2;
    reset = 1'b0;
    mem_wait = 1'b0;
    #1;
    checks++;
    if (stats !== 13'h0) begin
      errors++; $display("[TB] FAIL rst_mid_stats: got %h want %h", stats, 13'h0);
    end
    checks++;
    if (ctl !== CTL_RUN) begin
      errors++; $display("[TB] FAIL rst_mid_ctl: got %b want %b", ctl, CTL_RUN);
    end
    @(negedge clk);
    reset = 1'b1;
    mem_wait = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      expStats = {4'(k), 4'd0, 4'd0, 1'((k >= TIMEOUT) ? 1 : 0)};
      @(posedge clk); #1;
      checks++;
      if (stats !== expStats) begin
        errors++; $display("[TB] FAIL rst_rewait_stats[%0d]: got %h want %h", k, stats, expStats);
      end
    end
    @(negedge clk);
    clearInputs();
  endtask

  // Run every scenario in order and report.
  initial begin
    test_reset();
    test_load_use();
    test_branch();
    test_jump();
    test_mem_wait();
    test_timeout();
    test_saturation_and_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
